hc_axi_mem_slave: RTL

- AXI4 slave memory responder: the far end of the hardcloud AXI master channels (if_axi_in reads, if_axi_out writes).
- Holds DEPTH lines of DATA_WIDTH bits and services INCR bursts on AR/R and AW/W/B.
- Used as the memory behind the hif master in simulation benches and as an on-chip scratch buffer in loopback builds.
- Read and write paths are independent state machines sharing one memory array.

---
 rtl/hc_axi_mem_slave.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/hc_axi_mem_slave.sv
// hc_axi_mem_slave: AXI4 slave memory responder with DEPTH lines of DATA_WIDTH bits.
// Services INCR bursts on AR/R and AW/W/B with independent read and write FSMs
// sharing one memory array.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   axi_aw*/axi_w*/axi_b*  write address, data and response channels
//   axi_ar*/axi_r*         read address and data channels
//   rd_bursts, wr_bursts   completed burst counters (wrap)
//   err                    sticky protocol error
// Optional feature: define HC_AXI_MEM_SLAVE_LAST_CHECK_EN to flag wlast/beat-count
// disagreement and bursts that wrap past line DEPTH-1 on err. Otherwise err is 0.
module hc_axi_mem_slave #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 512,
    parameter int unsigned           DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]              axi_awlen,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wlast,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [7:0]              axi_arlen,
    output logic                    axi_rvalid,
    input  logic                    axi_rready,
    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic                    axi_rlast,
    output logic [31:0]             rd_bursts,
    output logic [31:0]             wr_bursts,
    output logic                    err
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    r_state_t         r_state, r_state_nxt;
    w_state_t         w_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [7:0]       r_cnt, w_cnt;
    logic             arready_nxt, rvalid_nxt, rlast_nxt;
    logic             awready_nxt, wready_nxt, bvalid_nxt;
    logic             r_beat, w_beat;

    // Byte offset from BASE_ADDR; the line index sits just above the in-line offset bits
    logic [ADDR_WIDTH-1:0] ar_off, aw_off;
    assign ar_off = axi_araddr - BASE_ADDR;
    assign aw_off = axi_awaddr - BASE_ADDR;

    assign r_beat = (r_state == R_DATA) && axi_rready;
    assign w_beat = (w_state == W_DATA) && axi_wvalid;

    // Read FSM: state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= R_IDLE;
            axi_arready <= 1'b1;
            axi_rvalid  <= 1'b0;
            axi_rlast   <= 1'b0;
        end else begin
            r_state     <= r_state_nxt;
            axi_arready <= arready_nxt;
            axi_rvalid  <= rvalid_nxt;
            axi_rlast   <= rlast_nxt;
        end
    end

    // Read FSM: next state
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (axi_arvalid) r_state_nxt = R_FETCH;
            R_FETCH: r_state_nxt = R_DATA;
            R_DATA:  if (r_beat) r_state_nxt = (r_cnt == 8'd0) ? R_IDLE : R_FETCH;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM: outputs decoded from the next state so they come straight off flops
    always_comb begin
        arready_nxt = (r_state_nxt == R_IDLE);
        rvalid_nxt  = (r_state_nxt == R_DATA);
        rlast_nxt   = rvalid_nxt && (r_cnt == 8'd0);
    end

    // Read datapath: address/count tracking, registered memory read, burst counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_cnt     <= '0;
            axi_rdata <= '0;
            rd_bursts <= '0;
        end else begin
            if (r_state == R_IDLE && axi_arvalid) begin
                r_idx <= ar_off[OFF_W +: IDX_W];
                r_cnt <= axi_arlen;
            end
            if (r_state == R_FETCH) axi_rdata <= mem[r_idx];
            if (r_beat) begin
                if (r_cnt == 8'd0) begin
                    rd_bursts <= rd_bursts + 32'd1;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                    r_cnt <= r_cnt - 8'd1;
                end
            end
        end
    end

    // Write FSM: state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state     <= W_IDLE;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
        end else begin
            w_state     <= w_state_nxt;
            axi_awready <= awready_nxt;
            axi_wready  <= wready_nxt;
            axi_bvalid  <= bvalid_nxt;
        end
    end

    // Write FSM: next state; the burst ends on the beat count, wlast is not trusted
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (axi_awvalid) w_state_nxt = W_DATA;
            W_DATA:  if (w_beat && w_cnt == 8'd0) w_state_nxt = W_RESP;
            W_RESP:  if (axi_bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM: outputs
    always_comb begin
        awready_nxt = (w_state_nxt == W_IDLE);
        wready_nxt  = (w_state_nxt == W_DATA);
        bvalid_nxt  = (w_state_nxt == W_RESP);
    end

    // Write datapath: address/count tracking and burst counter
    always_ff @(posedge clk) begin
        if (rst) begin
            w_idx     <= '0;
            w_cnt     <= '0;
            wr_bursts <= '0;
        end else begin
            if (w_state == W_IDLE && axi_awvalid) begin
                w_idx <= aw_off[OFF_W +: IDX_W];
                w_cnt <= axi_awlen;
            end
            if (w_beat && w_cnt != 8'd0) begin
                w_idx <= w_idx + IDX_W'(1);
                w_cnt <= w_cnt - 8'd1;
            end
            if (w_state == W_RESP && axi_bready) wr_bursts <= wr_bursts + 32'd1;
        end
    end

    // Byte-masked memory write; a same-cycle fetch sees the old line
    always_ff @(posedge clk) begin
        if (!rst && w_beat) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
        end
    end

`ifdef HC_AXI_MEM_SLAVE_LAST_CHECK_EN
    // Sticky error: wlast disagreeing with the beat count, or a burst stepping past the last line
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((w_beat && (axi_wlast != (w_cnt == 8'd0))) ||
                     (w_beat && w_cnt != 8'd0 && w_idx == {IDX_W{1'b1}}) ||
                     (r_beat && r_cnt != 8'd0 && r_idx == {IDX_W{1'b1}})) begin
            err <= 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ar_off[OFF_W-1:0], ar_off[ADDR_WIDTH-1:OFF_W+IDX_W],
                           aw_off[OFF_W-1:0], aw_off[ADDR_WIDTH-1:OFF_W+IDX_W]};
`else
    assign err = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{ar_off[OFF_W-1:0], ar_off[ADDR_WIDTH-1:OFF_W+IDX_W],
                           aw_off[OFF_W-1:0], aw_off[ADDR_WIDTH-1:OFF_W+IDX_W], axi_wlast};
`endif

endmodule
